// File: rtl/msrv32_store_unit.sv
// ---------------------------------------------------------------------------
// msrv32_store_unit
//   Store unit that sits behind the decoder. It captures a store request,
//   formats the bus address/data/byte-mask, runs a request/ready handshake
//   with the data bus, stalls the pipeline until the bus accepts, and aborts
//   with a bus-error pulse when the bus stays silent for TIMEOUT_CYCLES.
//
// Ports
//   ms_riscv32_mp_clk_in         clock, rising edge
//   ms_riscv32_mp_rst_in         synchronous reset, active high
//   mem_wr_req_in                store request from the decoder
//   funct3_in[1:0]               store size: 00 SB, 01 SH, 1x SW
//   iadder_in[31:0]              byte address of the store
//   rs2_in[31:0]                 store source data
//   ms_riscv32_mp_dmwr_ready_in  bus accepts the current write
//   ms_riscv32_mp_dmaddr_out     word-aligned bus address
//   ms_riscv32_mp_dmdata_out     lane-replicated write data
//   ms_riscv32_mp_dmwr_mask_out  byte enables, bit i = byte lane i
//   ms_riscv32_mp_dmwr_req_out   write request to the bus
//   stall_out                    pipeline stall request (combinational)
//   store_done_out               1-cycle pulse, store accepted by the bus
//   bus_err_out                  1-cycle pulse, store aborted on timeout
// ---------------------------------------------------------------------------
module msrv32_store_unit #(
    parameter int TIMEOUT_CYCLES = 16,  // 0 disables the timeout
    parameter int CNT_W          = 5
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic        mem_wr_req_in,
    input  logic [1:0]  funct3_in,
    input  logic [31:0] iadder_in,
    input  logic [31:0] rs2_in,
    input  logic        ms_riscv32_mp_dmwr_ready_in,
    output logic [31:0] ms_riscv32_mp_dmaddr_out,
    output logic [31:0] ms_riscv32_mp_dmdata_out,
    output logic [3:0]  ms_riscv32_mp_dmwr_mask_out,
    output logic        ms_riscv32_mp_dmwr_req_out,
    output logic        stall_out,
    output logic        store_done_out,
    output logic        bus_err_out
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Counter value on the last permitted WAIT cycle without ready.
    localparam logic [CNT_W-1:0] TO_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             ready_hit;
    logic             timeout_hit;
    logic [31:0]      data_fmt;
    logic [3:0]       mask_fmt;

    // Lane formatting. Misaligned offsets are not filtered here: the
    // decoder suppresses them, and the same rules apply if one slips by.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first,
        // so no path can leave it unassigned and infer a latch.
        data_fmt = rs2_in;
        mask_fmt = 4'b1111;
        case (funct3_in)
            2'b00: begin
                data_fmt = {4{rs2_in[7:0]}};
                mask_fmt = 4'b0001 << iadder_in[1:0];
            end
            2'b01: begin
                data_fmt = {2{rs2_in[15:0]}};
                mask_fmt = iadder_in[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    // Next-state logic. Ready is tested before the timeout so that a bus
    // acceptance on the final cycle completes the store instead of aborting.
    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        ready_hit   = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (mem_wr_req_in) begin
                    accept    = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (ms_riscv32_mp_dmwr_ready_in) begin
                    ready_hit = 1'b1;
                    state_nxt = IDLE;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt == TO_LAST)) begin
                    timeout_hit = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register, timeout counter, captured bus fields and pulses.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (ms_riscv32_mp_rst_in) begin
            state                       <= IDLE;
            cnt                         <= '0;
            ms_riscv32_mp_dmaddr_out    <= '0;
            ms_riscv32_mp_dmdata_out    <= '0;
            ms_riscv32_mp_dmwr_mask_out <= '0;
            store_done_out              <= 1'b0;
            bus_err_out                 <= 1'b0;
        end else begin
            state          <= state_nxt;
            store_done_out <= ready_hit;
            bus_err_out    <= timeout_hit;
            if (accept) begin
                ms_riscv32_mp_dmaddr_out    <= {iadder_in[31:2], 2'b00};
                ms_riscv32_mp_dmdata_out    <= data_fmt;
                ms_riscv32_mp_dmwr_mask_out <= mask_fmt;
                cnt                         <= '0;
            end else if ((state == WAIT) && !ms_riscv32_mp_dmwr_ready_in) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Outputs. The bus request is exactly the WAIT state, so it rises one
    // cycle after the request and drops on the cycle done/err pulses.
    always_comb begin
        ms_riscv32_mp_dmwr_req_out = (state == WAIT);
        stall_out = ((state == IDLE) && mem_wr_req_in) ||
                    ((state == WAIT) && !ms_riscv32_mp_dmwr_ready_in);
    end

endmodule

// File: tb/tb_msrv32_store_unit.sv
// ---------------------------------------------------------------------------
// tb_msrv32_store_unit
//   Directed bench for msrv32_store_unit with hand-computed expectations.
//   Inputs change 1 ns after the rising edge; outputs are sampled 1 ns
//   later, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_msrv32_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_in = 1'b0;
    logic [1:0]  funct3 = 2'b00;
    logic [31:0] iadder = '0;
    logic [31:0] rs2 = '0;
    logic        ready = 1'b0;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic        req;
    logic        stall;
    logic        done;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    msrv32_store_unit #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .ms_riscv32_mp_clk_in        (clk),
        .ms_riscv32_mp_rst_in        (rst),
        .mem_wr_req_in               (req_in),
        .funct3_in                   (funct3),
        .iadder_in                   (iadder),
        .rs2_in                      (rs2),
        .ms_riscv32_mp_dmwr_ready_in (ready),
        .ms_riscv32_mp_dmaddr_out    (addr),
        .ms_riscv32_mp_dmdata_out    (data),
        .ms_riscv32_mp_dmwr_mask_out (mask),
        .ms_riscv32_mp_dmwr_req_out  (req),
        .stall_out                   (stall),
        .store_done_out              (done),
        .bus_err_out                 (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle 1 ns past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a store request on the decoder side.
    task automatic drive(input logic [1:0] f3, input logic [31:0] a, input logic [31:0] d);
        req_in = 1'b1;
        funct3 = f3;
        iadder = a;
        rs2    = d;
    endtask

    task automatic check_bus(input string tag, input logic [31:0] ea,
                             input logic [31:0] ed, input logic [3:0] em);
        check({tag, ".addr"}, addr, ea);
        check({tag, ".data"}, data, ed);
        check({tag, ".mask"}, {28'd0, mask}, {28'd0, em});
    endtask

    initial begin
        int cycles;

        // Reset state
        tick();
        tick();
        check("rst.req",  {31'd0, req},  32'd0);
        check("rst.done", {31'd0, done}, 32'd0);
        check("rst.err",  {31'd0, err},  32'd0);
        check_bus("rst", 32'h0, 32'h0, 4'h0);
        rst = 1'b0;

        // 1: SB at offset 3, ready tied high
        drive(2'b00, 32'h0000_1003, 32'hAABB_CCDD);
        ready = 1'b1;
        #1 check("t1.stall_idle", {31'd0, stall}, 32'd1);
        tick();
        req_in = 1'b0;
        #1;
        check("t1.req",   {31'd0, req},   32'd1);
        check("t1.stall", {31'd0, stall}, 32'd0);
        check_bus("t1", 32'h0000_1000, 32'hDDDD_DDDD, 4'b1000);
        tick();
        check("t1.req_off", {31'd0, req},  32'd0);
        check("t1.done",    {31'd0, done}, 32'd1);
        check("t1.err",     {31'd0, err},  32'd0);
        check_bus("t1.hold", 32'h0000_1000, 32'hDDDD_DDDD, 4'b1000);
        tick();
        check("t1.done_pulse", {31'd0, done}, 32'd0);

        // 2: SH at offset 2, ready after 3 WAIT cycles; stall counted
        cycles = 0;
        ready  = 1'b0;
        drive(2'b01, 32'h0000_2002, 32'h1234_ABCD);
        #1 if (stall) cycles++;
        tick();
        req_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 if (stall) cycles++;
            check("t2.req", {31'd0, req}, 32'd1);
            check_bus("t2.wait", 32'h0000_2000, 32'hABCD_ABCD, 4'b1100);
            tick();
        end
        ready = 1'b1;
        #1 if (stall) cycles++;
        check("t2.stall_cycles", cycles, 32'd4);
        tick();
        check("t2.done", {31'd0, done}, 32'd1);
        check("t2.req_off", {31'd0, req}, 32'd0);

        // 3: SW, ready never asserted -> timeout after 16 request cycles
        ready = 1'b0;
        drive(2'b10, 32'h0000_3004, 32'h55AA_33CC);
        tick();
        req_in = 1'b0;
        check_bus("t3", 32'h0000_3004, 32'h55AA_33CC, 4'b1111);
        cycles = 0;
        for (int i = 0; i < 40 && req; i++) begin
            cycles++;
            check("t3.no_err_early", {31'd0, err}, 32'd0);
            tick();
        end
        check("t3.req_cycles", cycles, 32'd16);
        check("t3.err",  {31'd0, err},  32'd1);
        check("t3.done", {31'd0, done}, 32'd0);
        check("t3.req_off", {31'd0, req}, 32'd0);
        tick();
        check("t3.err_pulse", {31'd0, err}, 32'd0);

        // 4: ready arrives on the 16th WAIT cycle -> done wins
        drive(2'b11, 32'h0000_4000, 32'h0BAD_F00D);
        tick();
        req_in = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        ready = 1'b1;
        tick();
        check("t4.done", {31'd0, done}, 32'd1);
        check("t4.err",  {31'd0, err},  32'd0);
        ready = 1'b0;

        // 5: reset in WAIT drops the store; a new SW then runs normally
        drive(2'b10, 32'h0000_5000, 32'h1111_2222);
        tick();
        req_in = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5.req",  {31'd0, req},  32'd0);
        check("t5.done", {31'd0, done}, 32'd0);
        check("t5.err",  {31'd0, err},  32'd0);
        tick();
        check("t5.no_late_pulse", {31'd0, done | err}, 32'd0);
        drive(2'b10, 32'h0000_400B, 32'hCAFE_F00D);
        ready = 1'b1;
        tick();
        req_in = 1'b0;
        check("t5.new_req", {31'd0, req}, 32'd1);
        check_bus("t5.new", 32'h0000_4008, 32'hCAFE_F00D, 4'b1111);
        tick();
        check("t5.new_done", {31'd0, done}, 32'd1);

        // 6: back-to-back, second request held on the inputs during WAIT
        ready = 1'b0;
        drive(2'b00, 32'h0000_5001, 32'h1122_3344);
        tick();
        drive(2'b01, 32'h0000_6002, 32'h8765_4321);
        for (int i = 0; i < 2; i++) begin
            check_bus("t6.first", 32'h0000_5000, 32'h4444_4444, 4'b0010);
            tick();
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("t6.done1", {31'd0, done}, 32'd1);
        check("t6.stall_idle", {31'd0, stall}, 32'd1);
        tick();
        req_in = 1'b0;
        ready  = 1'b1;
        #1;
        check("t6.req2", {31'd0, req}, 32'd1);
        check_bus("t6.second", 32'h0000_6000, 32'h4321_4321, 4'b1100);
        tick();
        check("t6.done2", {31'd0, done}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
